gpmc_mem_arbiter: RTL and testbench
===================================

Name: gpmc_mem_arbiter

Overview:
- Shares one single-port register RAM (DATA_WIDTH x 2^ADDR_WIDTH) between two requesters.
- Port A is the host side, fed by the GPMC bus-slave decode strobes. Port B is the fabric side, e.g. a UART engine reading and writing its mailbox registers.
- Sequences one RAM access per cycle with round-robin arbitration, a 1-cycle read return path and a saturating contention counter.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- HOST_PRIO, 0, 1 = port A always wins ties; 0 = round-robin.
- CNT_WIDTH, 8, width of the contention counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held until a_gnt.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_gnt  out  1  port A grant pulse; access is issued this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_WIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en with ram_we=0.
- contention_cnt  out  CNT_WIDTH  number of cycles in which both requested.
- cnt_clr  in  1  synchronous clear of contention_cnt.

Behaviour:
- Reset (async, rst_n=0): all gnt, rvalid, ram_en, ram_we = 0; rdata, ram_addr, ram_wdata = 0; contention_cnt = 0; last_winner = B, so A wins the first tie.
- Grant logic is combinational from the req inputs and registered last_winner:
  - Only one requester: it is granted.
  - Both requesting, HOST_PRIO=1: A is granted.
  - Both requesting, HOST_PRIO=0: the port that is not last_winner is granted.
  - last_winner updates on every grant.
- Grant cycle: x_gnt=1, ram_en=1, and ram_we/ram_addr/ram_wdata are driven from the granted port in the same cycle (combinational mux). One grant per cycle; a requester may be granted in back-to-back cycles.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it samples gnt=1 at a posedge.
  - It then drops req or presents its next request.
  - req deasserted before grant = request withdrawn, no error.
- Read return:
  - Registered flag rd_pend_x is set on a read grant.
  - Next cycle: x_rvalid=1 for exactly one cycle and x_rdata = ram_rdata, registered at the end of that cycle and held until the next rvalid for that port.
  - Latency from gnt to rvalid is exactly 1 cycle.
  - Write grants produce no rvalid.
- Back-to-back: read A at cycle n and read B at cycle n+1 give a_rvalid at n+1 and b_rvalid at n+2. No bubbles.
- Same-address write then read from the other port in the next cycle returns the new data (RAM write-first ordering is sequenced by grant order).
- contention_cnt:
  - Increments in every cycle with a_req && b_req; saturates at all-ones.
  - cnt_clr=1 forces 0 at the next edge and takes priority over increment.
- Reset mid-operation clears rd_pend and rvalid. No stale rvalid follows reset deassertion.
- Starvation bound (HOST_PRIO=0): a continuously requesting port is granted within 2 cycles.

Test Plan:
- Reset, then a_req write addr 3 data 0xBEEF -> a_gnt and ram_en/ram_we=1, ram_addr=3, ram_wdata=0xBEEF in that cycle; no a_rvalid.
- Both read at once, addr A=1 / B=2, held 4 cycles, HOST_PRIO=0 -> grants alternate A,B,A,B; rvalid follows each grant by 1 cycle with the matching data; contention_cnt counts 1,2,3 then stops once only one request remains.
- HOST_PRIO=1, both requesting continuously for 5 cycles -> a_gnt every cycle, b_gnt never; contention_cnt=5.
- A writes 0x1234 to addr 7 at cycle n, B reads addr 7 at n+1 -> b_rvalid at n+2 with b_rdata=0x1234.
- Hold both requests 300 cycles with CNT_WIDTH=8 -> contention_cnt saturates at 255; then cnt_clr pulse -> 0 next cycle.
- Assert rst_n=0 in the cycle after a read grant -> no rvalid during or after reset; all outputs are 0; the first tie after reset goes to A.

Source files
------------

// File: rtl/gpmc_mem_arbiter.sv
// Two-port arbiter in front of a single-port register RAM: GPMC host on port A,
// fabric engine on port B, one access per cycle with a 1-cycle read return.
module gpmc_mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int HOST_PRIO  = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic [CNT_WIDTH-1:0]  contention_cnt,
    input  logic                  cnt_clr
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t                 last_winner;
    logic                  rd_pend_a;
    logic                  rd_pend_b;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    // Ties go to A under host priority, otherwise to whoever did not win last.
    always_comb begin
        a_gnt     = a_req && (!b_req || (HOST_PRIO != 0) || (last_winner == PORT_B));
        b_gnt     = b_req && !a_gnt;
        ram_en    = a_gnt || b_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (a_gnt) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (b_gnt) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner    <= PORT_B;
            rd_pend_a      <= 1'b0;
            rd_pend_b      <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            contention_cnt <= '0;
        end else begin
            if (a_gnt) begin
                last_winner <= PORT_A;
            end else if (b_gnt) begin
                last_winner <= PORT_B;
            end
            rd_pend_a <= a_gnt && !a_we;
            rd_pend_b <= b_gnt && !b_we;
            if (rd_pend_a) begin
                a_rdata_q <= ram_rdata;
            end
            if (rd_pend_b) begin
                b_rdata_q <= ram_rdata;
            end
            if (cnt_clr) begin
                contention_cnt <= '0;
            end else if (a_req && b_req && (contention_cnt != '1)) begin
                contention_cnt <= contention_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Read data is passed straight through in the rvalid cycle, then held.
    assign a_rvalid = rd_pend_a;
    assign b_rvalid = rd_pend_b;
    assign a_rdata  = rd_pend_a ? ram_rdata : a_rdata_q;
    assign b_rdata  = rd_pend_b ? ram_rdata : b_rdata_q;

endmodule

// File: tb/tb_gpmc_mem_arbiter.sv
// Bench for gpmc_mem_arbiter: round-robin and host-priority instances share stimulus,
// each with its own RAM and a behavioural reference model checked every cycle.
module tb_gpmc_mem_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int NW   = 1 << AW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we, cnt_clr;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic          a_gnt_w  [2];
    logic          b_gnt_w  [2];
    logic          a_rv_w   [2];
    logic          b_rv_w   [2];
    logic          ren_w    [2];
    logic          rwe_w    [2];
    logic [AW-1:0] raddr_w  [2];
    logic [DW-1:0] rwd_w    [2];
    logic [DW-1:0] ard_w    [2];
    logic [DW-1:0] brd_w    [2];
    logic [CW-1:0] cnt_w    [2];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: round-robin, instance 1: host priority; each owns a RAM.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [DW-1:0] mem [NW];
        logic [DW-1:0] rd_q;

        gpmc_mem_arbiter #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .HOST_PRIO (k),
            .CNT_WIDTH (CW)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .a_req         (a_req),
            .a_we          (a_we),
            .a_addr        (a_addr),
            .a_wdata       (a_wdata),
            .a_gnt         (a_gnt_w[k]),
            .a_rvalid      (a_rv_w[k]),
            .a_rdata       (ard_w[k]),
            .b_req         (b_req),
            .b_we          (b_we),
            .b_addr        (b_addr),
            .b_wdata       (b_wdata),
            .b_gnt         (b_gnt_w[k]),
            .b_rvalid      (b_rv_w[k]),
            .b_rdata       (brd_w[k]),
            .ram_en        (ren_w[k]),
            .ram_we        (rwe_w[k]),
            .ram_addr      (raddr_w[k]),
            .ram_wdata     (rwd_w[k]),
            .ram_rdata     (rd_q),
            .contention_cnt(cnt_w[k]),
            .cnt_clr       (cnt_clr)
        );

        initial for (int i = 0; i < NW; i++) mem[i] = '0;

        always @(posedge clk) begin
            if (ren_w[k]) begin
                if (rwe_w[k]) mem[raddr_w[k]] <= rwd_w[k];
                else          rd_q <= mem[raddr_w[k]];
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference model state, per instance.
    int            m_last [2];   // 0 = A won last, 1 = B won last
    bit            m_pa   [2];
    bit            m_pb   [2];
    logic [DW-1:0] m_ea   [2];
    logic [DW-1:0] m_eb   [2];
    logic [DW-1:0] m_ha   [2];
    logic [DW-1:0] m_hb   [2];
    int            m_cnt  [2];
    logic [DW-1:0] m_ram  [2][NW];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NW; i++) m_ram[k][i] = '0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("rst_a_gnt", k, a_gnt_w[k], 0);
                chk("rst_b_gnt", k, b_gnt_w[k], 0);
                chk("rst_a_rvalid", k, a_rv_w[k], 0);
                chk("rst_b_rvalid", k, b_rv_w[k], 0);
                chk("rst_ram_en", k, ren_w[k], 0);
                chk("rst_ram_we", k, rwe_w[k], 0);
                chk("rst_ram_addr", k, raddr_w[k], 0);
                chk("rst_ram_wdata", k, rwd_w[k], 0);
                chk("rst_a_rdata", k, ard_w[k], 0);
                chk("rst_b_rdata", k, brd_w[k], 0);
                chk("rst_cnt", k, cnt_w[k], 0);
                m_last[k] = 1;
                m_pa[k] = 0;  m_pb[k] = 0;
                m_ha[k] = '0; m_hb[k] = '0;
                m_cnt[k] = 0;
            end else begin
                bit ga, gb, both;
                both = a_req && b_req;
                if (both) begin
                    ga = (k == 1) ? 1'b1 : (m_last[k] == 1);
                end else begin
                    ga = a_req;
                end
                gb = b_req && !ga;

                chk("a_gnt", k, a_gnt_w[k], ga);
                chk("b_gnt", k, b_gnt_w[k], gb);
                chk("ram_en", k, ren_w[k], ga || gb);
                if (ga) begin
                    chk("ram_we", k, rwe_w[k], a_we);
                    chk("ram_addr", k, raddr_w[k], a_addr);
                    if (a_we) chk("ram_wdata", k, rwd_w[k], a_wdata);
                end else if (gb) begin
                    chk("ram_we", k, rwe_w[k], b_we);
                    chk("ram_addr", k, raddr_w[k], b_addr);
                    if (b_we) chk("ram_wdata", k, rwd_w[k], b_wdata);
                end
                chk("a_rvalid", k, a_rv_w[k], m_pa[k]);
                chk("b_rvalid", k, b_rv_w[k], m_pb[k]);
                chk("a_rdata", k, ard_w[k], m_pa[k] ? m_ea[k] : m_ha[k]);
                chk("b_rdata", k, brd_w[k], m_pb[k] ? m_eb[k] : m_hb[k]);
                chk("cnt", k, cnt_w[k], m_cnt[k]);

                if (m_pa[k]) m_ha[k] = m_ea[k];
                if (m_pb[k]) m_hb[k] = m_eb[k];
                m_pa[k] = ga && !a_we;
                m_pb[k] = gb && !b_we;
                if (ga) begin
                    if (a_we) m_ram[k][a_addr] = a_wdata;
                    else      m_ea[k] = m_ram[k][a_addr];
                    m_last[k] = 0;
                end
                if (gb) begin
                    if (b_we) m_ram[k][b_addr] = b_wdata;
                    else      m_eb[k] = m_ram[k][b_addr];
                    m_last[k] = 1;
                end
                if (cnt_clr)                    m_cnt[k] = 0;
                else if (both && m_cnt[k] < CMAX) m_cnt[k]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    endtask

    initial begin
        int a_left, b_left, i;
        rst_n = 1; cnt_clr = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        #2 rst_n = 0;
        repeat (3) tick();
        #3;
        chk("lit_rst_cnt", 0, cnt_w[0], 0);
        chk("lit_rst_rvalid", 0, a_rv_w[0], 0);
        tick();
        rst_n = 1;
        tick();

        // Host write to addr 3.
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 16'hBEEF;
        #3;
        chk("lit_wr_gnt", 0, a_gnt_w[0], 1);
        chk("lit_wr_en", 0, ren_w[0], 1);
        chk("lit_wr_we", 0, rwe_w[0], 1);
        chk("lit_wr_addr", 0, raddr_w[0], 3);
        chk("lit_wr_data", 0, rwd_w[0], 16'hBEEF);
        tick();
        idle();
        #3;
        chk("lit_wr_no_rvalid", 0, a_rv_w[0], 0);
        tick();

        // Seed addr 1/2; B wins last so the next tie goes to A.
        a_req = 1; a_we = 1; a_addr = 1; a_wdata = 16'h1111;
        tick();
        idle();
        b_req = 1; b_we = 1; b_addr = 2; b_wdata = 16'h2222;
        tick();
        idle();

        // Both read, two accesses each, held until granted.
        a_left = 2; b_left = 2; i = 0;
        a_addr = 1; b_addr = 2;
        while ((a_left > 0 || b_left > 0) && i < 10) begin
            a_req = (a_left > 0); b_req = (b_left > 0);
            #3;
            chk("lit_rr_a_gnt", 0, a_gnt_w[0], (i % 2) == 0);
            chk("lit_rr_b_gnt", 0, b_gnt_w[0], (i % 2) == 1);
            chk("lit_rr_cnt", 0, cnt_w[0], (i > 3) ? 3 : i);
            if (a_gnt_w[0]) a_left--;
            if (b_gnt_w[0]) b_left--;
            tick();
            i++;
        end
        idle();
        #3;
        chk("lit_rr_done", 0, (a_left == 0) && (b_left == 0), 1);
        chk("lit_rr_b_rvalid", 0, b_rv_w[0], 1);
        chk("lit_rr_b_rdata", 0, brd_w[0], 16'h2222);
        chk("lit_rr_a_rdata", 0, ard_w[0], 16'h1111);
        chk("lit_rr_cnt_end", 0, cnt_w[0], 3);
        tick();

        // Host priority: both requesting for 5 cycles.
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        a_req = 1; b_req = 1; a_addr = 4; b_addr = 5;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("lit_prio_a_gnt", 1, a_gnt_w[1], 1);
            chk("lit_prio_b_gnt", 1, b_gnt_w[1], 0);
            tick();
        end
        idle();
        #3;
        chk("lit_prio_cnt", 1, cnt_w[1], 5);
        tick();

        // Write from A, read-back from B the following cycle.
        a_req = 1; a_we = 1; a_addr = 7; a_wdata = 16'h1234;
        tick();
        idle();
        b_req = 1; b_addr = 7;
        #3;
        chk("lit_wr_rd_b_gnt", 0, b_gnt_w[0], 1);
        tick();
        idle();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("lit_wr_rd_rvalid", k, b_rv_w[k], 1);
            chk("lit_wr_rd_rdata", k, brd_w[k], 16'h1234);
        end
        tick();

        // Counter saturation and clear.
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        for (int c = 0; c < 300; c++) begin
            a_req = 1; b_req = 1;
            a_addr = AW'($urandom_range(0, NW - 1));
            b_addr = AW'($urandom_range(0, NW - 1));
            tick();
        end
        idle();
        #3;
        for (int k = 0; k < 2; k++) chk("lit_sat_cnt", k, cnt_w[k], CMAX);
        tick();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        #3;
        for (int k = 0; k < 2; k++) chk("lit_clr_cnt", k, cnt_w[k], 0);
        tick();

        // Reset in the cycle after a read grant.
        a_req = 1; a_addr = 3;
        #3;
        chk("lit_pre_rst_gnt", 0, a_gnt_w[0], 1);
        tick();
        idle();
        rst_n = 0;
        #3;
        chk("lit_in_rst_rvalid", 0, a_rv_w[0], 0);
        chk("lit_in_rst_rdata", 0, ard_w[0], 0);
        tick();
        tick();
        rst_n = 1;
        #3;
        chk("lit_post_rst_rvalid", 0, a_rv_w[0], 0);
        tick();
        a_req = 1; b_req = 1; a_addr = 3; b_addr = 7;
        #3;
        chk("lit_post_rst_tie_a", 0, a_gnt_w[0], 1);
        chk("lit_post_rst_tie_b", 0, b_gnt_w[0], 0);
        tick();
        idle();
        tick();

        // Randomized traffic with occasional clears and resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 255) != 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            a_req   = rst_n && ($urandom_range(0, 3) != 0);
            b_req   = rst_n && ($urandom_range(0, 3) != 0);
            a_we    = $urandom_range(0, 1) == 1;
            b_we    = $urandom_range(0, 1) == 1;
            a_addr  = AW'($urandom_range(0, NW - 1));
            b_addr  = AW'($urandom_range(0, NW - 1));
            a_wdata = DW'($urandom);
            b_wdata = DW'($urandom);
            tick();
        end
        rst_n = 1; cnt_clr = 0;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
